// File: rtl/pixel_write_queue.sv
// pixel_write_queue
// Buffers (x, y, colour) pixel strobes from the rectangle drawer in a small
// FIFO, converts each pixel to a linear framebuffer address and issues one
// write per pixel over a req/ack handshake (fb_we held until fb_ack).
// The drawer cannot be stalled, so pixels arriving into a full FIFO are
// dropped and the sticky overflow flag is raised.
//
// Optional feature macro: PIXEL_CLIP_EN
//   defined   - pixels outside SCREEN_W x SCREEN_H are silently discarded
//   undefined - every pixel is queued; the address simply wraps to 16 bits

module pixel_write_queue #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pixel_valid,
  input  logic [7:0]               x_in,
  input  logic [7:0]               y_in,
  input  logic [1:0]               color_in,
  input  logic                     clear_ovf,
  output logic                     fb_we,
  output logic [15:0]              fb_addr,
  output logic [1:0]               fb_data,
  input  logic                     fb_ack,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 18;  // {x[7:0], y[7:0], color[1:0]}
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Parameter sanity: the FIFO pointers wrap naturally only for powers of two,
  // and the whole screen must be addressable with 16 bits.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pixel_write_queue: DEPTH must be a power of 2 and at least 2");
  end
  if (SCREEN_W * SCREEN_H > 65536) begin : g_bad_screen
    $error("pixel_write_queue: screen does not fit a 16-bit address space");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01
  } state_e;

  // Linear framebuffer address; the multiply is by a constant and the
  // result intentionally wraps at 16 bits.
  function automatic logic [15:0] lin_addr(input logic [7:0] x, input logic [7:0] y);
    lin_addr = 16'(y) * 16'(SCREEN_W) + 16'(x);
  endfunction

  logic [EW-1:0]  mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  state_e         state_r;
  logic           fb_we_r;
  logic [15:0]    fb_addr_r;
  logic [1:0]     fb_data_r;
  logic           overflow_r;

  logic           empty_s;
  logic           full_s;
  logic           clip_ok_s;
  logic           push_req_s;
  logic           push_s;
  logic           drop_s;
  logic           load_s;
  logic [EW-1:0]  head_s;

  // Clip check: decides whether a strobed pixel is eligible for the FIFO.
  always_comb begin
    clip_ok_s = 1'b1;
`ifdef PIXEL_CLIP_EN
    if ((16'(x_in) < 16'(SCREEN_W)) && (16'(y_in) < 16'(SCREEN_H))) begin
      clip_ok_s = 1'b1;
    end else begin
      clip_ok_s = 1'b0;
    end
`else
    clip_ok_s = 1'b1;
`endif
  end

  // Push / pop decisions; a full FIFO still accepts a pixel when the head
  // leaves for the output stage on the same edge.
  always_comb begin
    empty_s    = (count_r == {CW{1'b0}});
    full_s     = (count_r == DEPTH_C);
    head_s     = mem_r[rd_ptr_r];
    push_req_s = pixel_valid & clip_ok_s;
    load_s     = 1'b0;
    if (!empty_s) begin
      if (state_r == ST_IDLE) begin
        load_s = 1'b1;
      end else if (state_r == ST_ISSUE && fb_ack) begin
        load_s = 1'b1;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
    push_s = push_req_s & (~full_s | load_s);
    drop_s = push_req_s & full_s & ~load_s;
  end

  // FIFO storage; contents need no reset because only counted entries are read.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= {x_in, y_in, color_in};
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, load_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write-issue FSM with registered request, address and data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      fb_we_r   <= 1'b0;
      fb_addr_r <= 16'd0;
      fb_data_r <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            state_r   <= ST_ISSUE;
            fb_we_r   <= 1'b1;
            fb_addr_r <= lin_addr(head_s[17:10], head_s[9:2]);
            fb_data_r <= head_s[1:0];
          end else begin
            state_r   <= ST_IDLE;
            fb_we_r   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (fb_ack) begin
            if (load_s) begin
              state_r   <= ST_ISSUE;
              fb_we_r   <= 1'b1;
              fb_addr_r <= lin_addr(head_s[17:10], head_s[9:2]);
              fb_data_r <= head_s[1:0];
            end else begin
              state_r   <= ST_IDLE;
              fb_we_r   <= 1'b0;
            end
          end else begin
            state_r   <= ST_ISSUE;
            fb_we_r   <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          fb_we_r   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign fb_we      = fb_we_r;
  assign fb_addr    = fb_addr_r;
  assign fb_data    = fb_data_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;
  assign idle       = empty_s & ~fb_we_r;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: table-driven pixel vectors,
// a scoreboard of expected writes, and hand sequences for stall, clip and
// reset corner cases.

module tb_pixel_write_queue;

  logic        clk;
  logic        rst;
  logic        pixel_valid;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [1:0]  color_in;
  logic        clear_ovf;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_ack;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        idle;

  pixel_write_queue #(.DEPTH(8), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .x_in(x_in), .y_in(y_in),
    .color_in(color_in), .clear_ovf(clear_ovf), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_ack(fb_ack), .fifo_count(fifo_count),
    .overflow(overflow), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [1:0]  c;
    logic [15:0] addr;
  } vec_t;

  vec_t         vecs [14];
  logic [17:0]  sb [$];   // expected {addr, data}
  int           n_checks;
  int           n_fail;
  int           n_writes;
  int           cyc;
  int           mark_writes;
  int           first_wr_cyc;
  int           last_wr_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // One clock: observe the handshake at the negedge, then land 1 time unit
  // after the next rising edge where inputs are driven and state is checked.
  task automatic tick();
    logic [17:0] exp_w;
    @(negedge clk);
    if (fb_we === 1'b1 && fb_ack === 1'b1) begin
      if (n_writes == mark_writes) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      n_writes++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: actual addr %0d, required no write", fb_addr);
      end else begin
        exp_w = sb.pop_front();
        check("wr_addr", 32'(fb_addr), 32'(exp_w[17:2]));
        check("wr_data", 32'(fb_data), 32'(exp_w[1:0]));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [1:0] c);
    pixel_valid = 1'b1;
    x_in = x;
    y_in = y;
    color_in = c;
  endtask

  initial begin
    int c0;
    n_checks = 0; n_fail = 0; n_writes = 0; cyc = 0;
    mark_writes = 0; first_wr_cyc = -1; last_wr_cyc = -1;

    // burst of x=0..9, y=0 followed by assorted positions
    for (int i = 0; i < 10; i++) vecs[i] = '{8'(i), 8'd0, 2'(i % 4), 16'(i)};
    vecs[10] = '{8'd0,   8'd1,   2'd3, 16'd160};
    vecs[11] = '{8'd7,   8'd50,  2'd2, 16'd8007};
    vecs[12] = '{8'd100, 8'd100, 2'd1, 16'd16100};
    vecs[13] = '{8'd159, 8'd119, 2'd0, 16'd19199};

    rst = 1'b1; pixel_valid = 1'b0; x_in = 8'd0; y_in = 8'd0; color_in = 2'd0;
    clear_ovf = 1'b0; fb_ack = 1'b0;
    tick(); tick();
    // reset state
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_data", 32'(fb_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    rst = 1'b0;
    tick();

    // single pixel: request two cycles after the strobe
    drive(8'd3, 8'd2, 2'd1);
    sb.push_back({16'd323, 2'd1});
    tick();
    pixel_valid = 1'b0;
    check("single_we_early", 32'(fb_we), 32'd0);
    check("single_count", 32'(fifo_count), 32'd1);
    tick();
    check("single_we", 32'(fb_we), 32'd1);
    check("single_addr", 32'(fb_addr), 32'd323);
    check("single_data", 32'(fb_data), 32'd1);
    check("single_idle_busy", 32'(idle), 32'd0);
    fb_ack = 1'b1;
    tick();
    fb_ack = 1'b0;
    check("single_we_done", 32'(fb_we), 32'd0);
    check("single_idle", 32'(idle), 32'd1);
    check("single_writes", 32'(n_writes), 32'd1);

    // table-driven burst with ack tied high: no gaps once started
    fb_ack = 1'b1;
    mark_writes = n_writes;
    c0 = cyc;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].x, vecs[i].y, vecs[i].c);
      sb.push_back({vecs[i].addr, vecs[i].c});
      tick();
    end
    pixel_valid = 1'b0;
    drain(40);
    check("burst_writes", 32'(n_writes - mark_writes), 32'd14);
    check("burst_latency", 32'(first_wr_cyc - c0), 32'd2);
    check("burst_no_gap", 32'(last_wr_cyc - first_wr_cyc), 32'd13);
    check("burst_ovf", 32'(overflow), 32'd0);
    check("burst_idle", 32'(idle), 32'd1);

    // stall: 10 pixels with ack low, the 10th is dropped
    fb_ack = 1'b0;
    mark_writes = n_writes;
    for (int i = 0; i < 10; i++) begin
      drive(8'(20 + i), 8'd3, 2'(i % 4));
      if (i < 9) sb.push_back({16'(500 + i), 2'(i % 4)});
      tick();
    end
    pixel_valid = 1'b0;
    check("stall_count", 32'(fifo_count), 32'd8);
    check("stall_ovf", 32'(overflow), 32'd1);
    check("stall_we", 32'(fb_we), 32'd1);
    check("stall_addr", 32'(fb_addr), 32'd500);
    check("stall_data", 32'(fb_data), 32'd0);
    tick();
    check("stall_hold_addr", 32'(fb_addr), 32'd500);
    fb_ack = 1'b1;
    drain(40);
    tick();
    fb_ack = 1'b0;
    check("stall_writes", 32'(n_writes - mark_writes), 32'd9);
    check("stall_ovf_sticky", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // clip: off-screen pixel followed by the last on-screen pixel
    fb_ack = 1'b1;
    mark_writes = n_writes;
    drive(8'd160, 8'd5, 2'd2);
`ifndef PIXEL_CLIP_EN
    sb.push_back({16'd960, 2'd2});
`endif
    tick();
    drive(8'd159, 8'd119, 2'd3);
    sb.push_back({16'd19199, 2'd3});
    tick();
    pixel_valid = 1'b0;
    drain(20);
    tick(); tick(); tick();
`ifdef PIXEL_CLIP_EN
    check("clip_writes", 32'(n_writes - mark_writes), 32'd1);
`else
    check("noclip_writes", 32'(n_writes - mark_writes), 32'd2);
`endif
    check("clip_ovf", 32'(overflow), 32'd0);

    // reset mid-write with 3 entries queued; pixel in reset cycle ignored
    fb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(i), 8'd10, 2'd1);
      sb.push_back({16'(1600 + i), 2'd1});
      tick();
    end
    pixel_valid = 1'b0;
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    check("pre_rst_we", 32'(fb_we), 32'd1);
    rst = 1'b1;
    drive(8'd1, 8'd1, 2'd3);
    tick();
    rst = 1'b0;
    pixel_valid = 1'b0;
    sb.delete();
    check("mid_rst_we", 32'(fb_we), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    check("mid_rst_addr", 32'(fb_addr), 32'd0);
    fb_ack = 1'b1;
    mark_writes = n_writes;
    for (int k = 0; k < 10; k++) tick();
    check("post_rst_no_writes", 32'(n_writes - mark_writes), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_queue.md
# pixel_write_queue

Downstream consumer of the rectangle drawer's pixel stream. It buffers `(x, y)` pixel strobes in a small FIFO, clips them to the screen, converts each pixel to a linear framebuffer address, and issues one write request per pixel over a req/ack handshake. The drawer has no backpressure input, so this block absorbs bursts and flags any pixel it has to drop.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of 2, minimum 2.
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: **synchronous, active-high** reset.
- `pixel_valid` in 1: one pixel strobe per cycle.
- `x_in` in 8: pixel X; sampled when `pixel_valid` is high.
- `y_in` in 8: pixel Y; sampled when `pixel_valid` is high.
- `color_in` in 2: pixel colour; sampled when `pixel_valid` is high.
- `clear_ovf` in 1: clears the `overflow` flag.
- `fb_we` out 1: write request; held high until acknowledged.
- `fb_addr` out 16: `y*SCREEN_W + x`.
- `fb_data` out 2: colour to write.
- `fb_ack` in 1: framebuffer accepted the write this cycle; only meaningful while `fb_we` is high.
- `fifo_count` out $clog2(DEPTH)+1: number of entries in the FIFO; the output stage is not counted.
- `overflow` out 1: sticky; set when a pixel is dropped because the FIFO is full.
- `idle` out 1: high when the FIFO is empty and `fb_we` is low.

## Operation
- **Storage.** A FIFO of `{x, y, color}` entries, plus one output-stage register holding `fb_addr` and `fb_data`.
- **Push.**
  - Occurs when `pixel_valid` is high and the pixel passes the clip check.
  - Accepted if the FIFO is not full.
  - When full, it is accepted only if a load (below) happens in the same cycle.
  - Otherwise the pixel is discarded and `overflow` is set to 1.
- **Load (pop).** The FIFO head moves into the output stage on an edge where the FIFO is non-empty and either:
  - state is IDLE, or
  - state is ISSUE and `fb_ack` is high.
- **Address calculation.** `fb_addr <= y*SCREEN_W + x`, computed at load. The multiply is a constant multiply, 16-bit unsigned result.
- **State machine.**
  - IDLE: `fb_we` is 0. On a load, go to ISSUE.
  - ISSUE: `fb_we` is 1, and `fb_addr`/`fb_data` hold stable.
  - In ISSUE with `fb_ack`: if the FIFO is non-empty, load the next entry and stay in ISSUE (back-to-back writes). If the FIFO is empty, go to IDLE.
  - Unused state encodings go to IDLE.
- **Overflow flag.**
  - `clear_ovf` clears it.
  - If a clear and a drop happen in the same cycle, set wins.
- **Simultaneous push and pop on an empty FIFO.** Cannot occur: the pushed entry is not visible to the load logic until the next cycle.
- **`fifo_count`.** Increments on an accepted push, decrements on a load, and is unchanged when both happen in the same cycle.
- **Reset.**
  - Synchronous. Takes effect at the edge where `rst` is high, including mid-write.
  - Afterwards: state IDLE, FIFO empty, and `fb_we=0`, `fb_addr=0`, `fb_data=0`, `fifo_count=0`, `overflow=0`, `idle=1`.
  - In-flight and queued pixels are discarded. A pixel presented in the reset cycle is ignored.

## Timing
- **Latency.** A pixel presented at edge N on an idle, empty block is written into the FIFO at edge N. It loads at edge N+1, and `fb_we` is high in the cycle after edge N+1. That is two cycles from strobe to request.
- **Throughput.** With `fb_ack` held high, one write per cycle, sustained.
- **Stall.** With `fb_ack` low, the FIFO absorbs `DEPTH` further pixels. The next pixel after that is dropped (the output stage holds one more).
- **Registered outputs.** `fb_addr` and `fb_data` change only on a load edge.
- **`idle` is combinational** from FIFO-empty and state.

## Configuration
- **`PIXEL_CLIP_EN` defined:**
  - Pixels with `x_in >= SCREEN_W` or `y_in >= SCREEN_H` are not pushed.
  - They do not set `overflow`.
- **`PIXEL_CLIP_EN` undefined:**
  - Every pixel is pushed.
  - The address is computed as `y*SCREEN_W + x`, truncated to 16 bits, with no range check.

## Test plan
- **Single pixel.** After reset, `x=3, y=2, color=1` strobed once → `fb_we` high two cycles later with `fb_addr=323`, `fb_data=1`. With `fb_ack` held 1 cycle → `fb_we` low the next cycle, `idle=1`.
- **Burst.** Pixels `x=0..9, y=0` on consecutive cycles, `fb_ack` tied high → addresses 0..9 on consecutive cycles, with no gaps once started. `overflow` stays 0.
- **Stall and overflow.** `fb_ack=0`, `DEPTH=8`, 10 consecutive pixels → first pixel in the output stage, `fifo_count=8`, 10th pixel dropped, `overflow=1`. Then release ack → exactly 9 writes, in order. Then `clear_ovf` → `overflow=0`.
- **Clip.** With `PIXEL_CLIP_EN`: `x=160, y=5` then `x=159, y=119` → a single write, `fb_addr=19199`.
- **Clip disabled.** Without the macro, `x=160, y=5` → write with `fb_addr=960`.
- **Reset mid-write.** Assert `rst` for 1 cycle while in ISSUE with 3 entries queued → the next cycle shows `fb_we=0`, `fifo_count=0`, `idle=1`, and no further writes occur.
